brightness_oe_sequencer: RTL and testbench
==========================================

Name: brightness_oe_sequencer

Overview:
Parametrised successor to the per-plane brightness timeout. It generates the panel output-enable window for one bit-plane of binary-coded modulation. Each row_latch starts a fixed-length plane slot with blanking dead-time, a globally dimmable ON window, and an OFF remainder. The block sits between the row/plane scheduler (which supplies row_latch and the one-hot plane mask) and the OE pad driver, which inverts OE to the panel's active-low pin.

Parameters:
BRIGHTNESS_LEVELS, params_pkg::BRIGHTNESS_LEVELS, number of bit-planes; width of the plane mask.
BASE_TIMEOUT, 23, slot length in clocks of plane 0 (LSB).
DIM_BITS, 4, width of the global dimming input.
BLANK_CYCLES, 2, OE-low dead-time after each latch (0 allowed).

Ports:
clk_in  input  1  system clock.
reset  input  1  synchronous, active-high reset.
row_latch  input  1  single-cycle pulse; starts (or restarts) a slot.
brightness_mask_active  input  BRIGHTNESS_LEVELS  one-hot active plane; sampled only on row_latch.
global_dim  input  DIM_BITS  global brightness; sampled only on row_latch.
output_enable  output  1  active-high LED-on window.
exceeded_overlap_time  output  1  high when the slot has fully elapsed and the next latch is safe.
busy  output  1  high while a slot is in progress.
plane_done  output  1  one-cycle pulse when a slot completes.
mask_error  output  1  sticky flag for a non-one-hot nonzero mask sampled on a latch.

Behaviour:
- Reset (synchronous, active-high, on clk_in): state IDLE, output_enable=0, busy=0, plane_done=0, exceeded_overlap_time=1, mask_error=0, counter=0. Reset also aborts any slot in progress mid-operation.
- Widths: TW = $clog2(BASE_TIMEOUT)+BRIGHTNESS_LEVELS+1.
  - Slot length: T = BASE_TIMEOUT << k, where k is the index of the highest set mask bit.
  - ON length: on_cycles = (T*(global_dim+1)) >> DIM_BITS, computed in TW+DIM_BITS bits with no truncation before the shift.
  - Both values are latched into registers on row_latch.
- States: IDLE, BLANK, ON, OFF.
  - IDLE: row_latch with nonzero mask -> BLANK, or -> ON if BLANK_CYCLES=0, or -> OFF if on_cycles=0 as well.
  - BLANK: lasts exactly BLANK_CYCLES clocks -> ON, or -> OFF if on_cycles=0.
  - ON: output_enable=1 for exactly on_cycles clocks -> OFF.
  - OFF: lasts T-on_cycles clocks -> IDLE. If on_cycles=T, OFF is skipped and ON -> IDLE.
- Latency: the latch is sampled at edge N; busy=1 and exceeded_overlap_time=0 from the cycle after N.
  - The first output_enable=1 cycle is N+1+BLANK_CYCLES.
  - Total busy duration is BLANK_CYCLES+T clocks, independent of global_dim, so plane timing never changes with dimming.
- Completion: on the cycle the state returns to IDLE, busy=0, exceeded_overlap_time=1, and plane_done=1 for exactly one cycle.
- Retrigger: row_latch while busy aborts the current slot, drops output_enable the next cycle, resamples mask and dim, and restarts at BLANK. No plane_done is issued for the aborted slot.
- Zero mask on row_latch: ignored; the state is unchanged, including if busy. mask_error is not set.
- Multi-bit mask: the highest set bit is used and mask_error is set; only reset clears it.
- Inputs changing while not latching have no effect.
- output_enable is driven from a register (glitch-free); it is never high outside state ON.

Test Plan:
1. BASE=23, DIM_BITS=4, BLANK=2; mask=1<<1, dim=15, latch at N -> OE high N+3..N+48 (46 cycles), busy N+1..N+48, plane_done at N+49, exceeded returns to 1 at N+49.
2. Same with dim=7 -> OE high for 23 cycles, then OFF for 23; total busy still 48. dim=0 with mask=1<<0 -> OE high 1 cycle ((23*1)>>4), busy 25.
3. BASE_TIMEOUT=3, mask=1<<0, dim=0 -> on_cycles=0: OE never asserts, busy 5 cycles, plane_done pulses once.
4. Retrigger: latch mask=1<<2 (T=92), re-latch mask=1<<0 at cycle 10 of ON -> OE low next cycle, new slot busy 25 cycles, exactly one plane_done.
5. Sweep mask 1<<0..1<<(BRIGHTNESS_LEVELS-1), dim=15 -> each OE width equals 23<<k; a zero-mask latch -> no state change; mask=0b101 -> uses bit 2 and mask_error=1 until reset.
6. Assert reset mid-ON -> next cycle OE=0, busy=0, exceeded=1, no plane_done; the next latch behaves as in scenario 1.

Source files
------------

// File: rtl/params_pkg.sv
// ============================================================================
// Module   : params_pkg
// Brief    : Shared build-time parameters for the LED panel pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package params_pkg;
    parameter int BRIGHTNESS_LEVELS = 4;
endpackage

`default_nettype wire

// File: rtl/brightness_oe_sequencer_if.sv
// ============================================================================
// Module   : brightness_oe_sequencer_if
// Brief    : Scheduler-to-sequencer control and status bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface brightness_oe_sequencer_if #(
    parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
    parameter int DIM_BITS          = 4
);
    logic                         row_latch;
    logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active;
    logic [DIM_BITS-1:0]          global_dim;
    logic                         output_enable;
    logic                         exceeded_overlap_time;
    logic                         busy;
    logic                         plane_done;
    logic                         mask_error;

    modport master (
        output row_latch, brightness_mask_active, global_dim,
        input  output_enable, exceeded_overlap_time, busy, plane_done, mask_error
    );

    modport slave (
        input  row_latch, brightness_mask_active, global_dim,
        output output_enable, exceeded_overlap_time, busy, plane_done, mask_error
    );
endinterface

`default_nettype wire

// File: rtl/brightness_oe_sequencer.sv
// ============================================================================
// Module   : brightness_oe_sequencer
// Brief    : Per-bit-plane OE window generator: blanking, dimmable ON, OFF.
// Revision : 1.0
// ============================================================================
`default_nettype none

module brightness_oe_sequencer #(
    parameter int BRIGHTNESS_LEVELS = params_pkg::BRIGHTNESS_LEVELS,
    parameter int BASE_TIMEOUT      = 23,
    parameter int DIM_BITS          = 4,
    parameter int BLANK_CYCLES      = 2
) (
    input  wire logic                 clk_in,
    input  wire logic                 reset,
    brightness_oe_sequencer_if.slave  bus
);
    localparam int TW = $clog2(BASE_TIMEOUT) + BRIGHTNESS_LEVELS + 1;
    localparam int PW = TW + DIM_BITS;
    localparam int KW = (BRIGHTNESS_LEVELS > 1) ? $clog2(BRIGHTNESS_LEVELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2,
        S_OFF   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_cnt;
    logic [TW-1:0]   w_cnt_nxt;
    logic [TW-1:0]   r_on;
    logic [TW-1:0]   w_on_nxt;
    logic [TW-1:0]   r_off;
    logic [TW-1:0]   w_off_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic            w_done_nxt;
    logic            r_oe;
    logic            r_busy;
    logic            r_exceeded;
    logic            r_done;

    logic [KW-1:0]   w_k;
    logic [TW-1:0]   w_slot;
    logic [PW-1:0]   w_prod;
    logic [TW-1:0]   w_on_calc;
    logic            w_start;
    logic            w_multi;

    // Slot length and ON length derived from the mask/dim presented with the latch
    always_comb begin
        w_k = '0;
        for (int i = 0; i < BRIGHTNESS_LEVELS; i++) begin
            if (bus.brightness_mask_active[i]) w_k = KW'(i);
        end
        w_slot    = TW'(BASE_TIMEOUT) << w_k;
        w_prod    = PW'(w_slot) * PW'({1'b0, bus.global_dim} + 1'b1);
        w_on_calc = TW'(w_prod >> DIM_BITS);
        w_start   = bus.row_latch && (bus.brightness_mask_active != '0);
        w_multi   = (bus.brightness_mask_active &
                     (bus.brightness_mask_active - 1'b1)) != '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_on_nxt    = r_on;
        w_off_nxt   = r_off;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;

        if (w_start) begin
            w_on_nxt  = w_on_calc;
            w_off_nxt = w_slot - w_on_calc;
            w_err_nxt = r_err | w_multi;
            if (BLANK_CYCLES > 0) begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = TW'(BLANK_CYCLES - 1);
            end else if (w_on_calc != '0) begin
                w_state_nxt = S_ON;
                w_cnt_nxt   = w_on_calc - 1'b1;
            end else begin
                w_state_nxt = S_OFF;
                w_cnt_nxt   = w_slot - 1'b1;
            end
        end else begin
            case (r_state)
                S_BLANK: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (r_on != '0) begin
                        w_state_nxt = S_ON;
                        w_cnt_nxt   = r_on - 1'b1;
                    end else begin
                        w_state_nxt = S_OFF;
                        w_cnt_nxt   = r_off - 1'b1;
                    end
                end
                S_ON: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else if (r_off != '0) begin
                        w_state_nxt = S_OFF;
                        w_cnt_nxt   = r_off - 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                S_OFF: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered, not combinational
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_on       <= '0;
            r_off      <= '0;
            r_err      <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_exceeded <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_on       <= w_on_nxt;
            r_off      <= w_off_nxt;
            r_err      <= w_err_nxt;
            r_oe       <= (w_state_nxt == S_ON);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_exceeded <= (w_state_nxt == S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign bus.output_enable         = r_oe;
    assign bus.busy                  = r_busy;
    assign bus.exceeded_overlap_time = r_exceeded;
    assign bus.plane_done            = r_done;
    assign bus.mask_error            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_brightness_oe_sequencer.sv
// ============================================================================
// Module   : tb_brightness_oe_sequencer
// Brief    : Self-checking bench: slot-timeline model plus directed scenarios.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_brightness_oe_sequencer;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       latch;
    logic [3:0] mask;
    logic [3:0] dim;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    brightness_oe_sequencer_if #(.BRIGHTNESS_LEVELS(4), .DIM_BITS(4)) ifa ();
    brightness_oe_sequencer_if #(.BRIGHTNESS_LEVELS(4), .DIM_BITS(4)) ifb ();

    assign ifa.row_latch              = latch;
    assign ifa.brightness_mask_active = mask;
    assign ifa.global_dim             = dim;
    assign ifb.row_latch              = latch;
    assign ifb.brightness_mask_active = mask;
    assign ifb.global_dim             = dim;

    brightness_oe_sequencer #(
        .BRIGHTNESS_LEVELS(4), .BASE_TIMEOUT(23), .DIM_BITS(4), .BLANK_CYCLES(BLANK)
    ) dut_a (.clk_in(clk), .reset(rst), .bus(ifa));

    brightness_oe_sequencer #(
        .BRIGHTNESS_LEVELS(4), .BASE_TIMEOUT(3), .DIM_BITS(4), .BLANK_CYCLES(BLANK)
    ) dut_b (.clk_in(clk), .reset(rst), .bus(ifb));

    logic g_oe[2], g_busy[2], g_exc[2], g_done[2], g_err[2];
    assign g_oe[0]   = ifa.output_enable;
    assign g_busy[0] = ifa.busy;
    assign g_exc[0]  = ifa.exceeded_overlap_time;
    assign g_done[0] = ifa.plane_done;
    assign g_err[0]  = ifa.mask_error;
    assign g_oe[1]   = ifb.output_enable;
    assign g_busy[1] = ifb.busy;
    assign g_exc[1]  = ifb.exceeded_overlap_time;
    assign g_done[1] = ifb.plane_done;
    assign g_err[1]  = ifb.mask_error;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Model: each slot is a timeline indexed by d = cycles since the latching edge
    int base_v[2] = '{23, 3};
    int m_act[2], m_d[2], m_T[2], m_on[2], m_err[2];

    function automatic int hi_bit(input logic [3:0] m);
        int k = 0;
        for (int i = 0; i < 4; i++) if (m[i]) k = i;
        return k;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 0; m_d[i] = 0; m_err[i] = 0;
            end else if (latch && mask != 4'd0) begin
                m_T[i]   = base_v[i] << hi_bit(mask);
                m_on[i]  = (m_T[i] * (int'(dim) + 1)) >> 4;
                m_act[i] = 1;
                m_d[i]   = 1;
                if ($countones(mask) > 1) m_err[i] = 1;
            end else if (m_act[i] != 0) begin
                if (m_d[i] >= BLANK + m_T[i] + 1) m_act[i] = 0;
                else m_d[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int eb, eo, ed;
                eb = (m_act[i] != 0 && m_d[i] <= BLANK + m_T[i]) ? 1 : 0;
                eo = (m_act[i] != 0 && m_d[i] > BLANK && m_d[i] <= BLANK + m_on[i]) ? 1 : 0;
                ed = (m_act[i] != 0 && m_d[i] == BLANK + m_T[i] + 1) ? 1 : 0;
                check($sformatf("model_busy[%0d]", i), int'(g_busy[i]), eb);
                check($sformatf("model_oe[%0d]", i),   int'(g_oe[i]),   eo);
                check($sformatf("model_done[%0d]", i), int'(g_done[i]), ed);
                check($sformatf("model_exc[%0d]", i),  int'(g_exc[i]),  1 - eb);
                check($sformatf("model_err[%0d]", i),  int'(g_err[i]),  m_err[i]);
            end
        end
    end

    task automatic latch_pulse(input logic [3:0] m, input logic [3:0] dv);
        @(negedge clk); latch = 1'b1; mask = m; dim = dv;
        @(negedge clk); latch = 1'b0; mask = 4'($urandom); dim = 4'($urandom);
    endtask

    // Latch a slot and measure the selected instance until its plane_done
    task automatic run_slot(input int inst, input logic [3:0] m, input logic [3:0] dv,
                            input int zat, output int first_oe, output int n_oe,
                            output int n_busy, output int n_done, output int done_at);
        first_oe = 0; n_oe = 0; n_busy = 0; n_done = 0; done_at = 0;
        latch_pulse(m, dv);
        for (int d = 1; d <= 400 && done_at == 0; d++) begin
            if (g_oe[inst]) begin
                n_oe++;
                if (first_oe == 0) first_oe = d;
            end
            if (g_busy[inst]) n_busy++;
            if (g_done[inst]) begin n_done++; done_at = d; end
            if (zat != 0 && d == zat) begin latch = 1'b1; mask = 4'd0; end
            else latch = 1'b0;
            if (done_at == 0) @(negedge clk);
        end
        latch = 1'b0;
        if (done_at == 0) check("slot_timeout", 0, 1);
    endtask

    task automatic check_slot(input string nm, input int inst, input logic [3:0] m,
                              input logic [3:0] dv, input int zat, input int e_first,
                              input int e_oe, input int e_busy);
        int f, o, b, nd, da;
        run_slot(inst, m, dv, zat, f, o, b, nd, da);
        check({nm, "_first_oe"}, f, e_first);
        check({nm, "_oe_len"},   o, e_oe);
        check({nm, "_busy_len"}, b, e_busy);
        check({nm, "_done_cnt"}, nd, 1);
        check({nm, "_done_at"},  da, e_busy + 1);
    endtask

    initial begin
        rst = 1'b1; latch = 1'b0; mask = 4'd0; dim = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_oe",   int'(g_oe[0]),   0);
        check("rst_busy", int'(g_busy[0]), 0);
        check("rst_exc",  int'(g_exc[0]),  1);
        check("rst_done", int'(g_done[0]), 0);
        check("rst_err",  int'(g_err[0]),  0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Full-brightness plane 1, half dim, dim=0 on plane 0
        check_slot("s1", 0, 4'b0010, 4'd15, 0, 3, 46, 48);
        check_slot("s2a", 0, 4'b0010, 4'd7, 0, 3, 23, 48);
        check_slot("s2b", 0, 4'b0001, 4'd0, 0, 3, 1, 25);
        // Short base: on_cycles rounds to zero
        check_slot("s3", 1, 4'b0001, 4'd0, 0, 0, 0, 5);

        // Retrigger during ON of a long slot
        latch_pulse(4'b0100, 4'd15);
        repeat (11) @(negedge clk);
        check("s4_oe_before", int'(g_oe[0]), 1);
        check_slot("s4", 0, 4'b0001, 4'd15, 0, 3, 23, 25);

        // Width sweep across planes
        for (int k = 0; k < 4; k++)
            check_slot($sformatf("s5_k%0d", k), 0, 4'(1 << k), 4'd15, 0, 3, 23 << k, 2 + (23 << k));
        check("s5_err_clean", int'(g_err[0]), 0);
        // Zero-mask latch mid-slot is ignored
        check_slot("s5_zero", 0, 4'b0010, 4'd15, 6, 3, 46, 48);
        latch_pulse(4'b0000, 4'd9);
        check("s5_zero_idle", int'(g_busy[0]), 0);
        // Multi-bit mask picks the highest bit and flags an error
        check_slot("s5_multi", 0, 4'b0101, 4'd15, 0, 3, 92, 94);
        check("s5_err_set", int'(g_err[0]), 1);
        check_slot("s5_err_hold", 0, 4'b0001, 4'd15, 0, 3, 23, 25);
        check("s5_err_sticky", int'(g_err[0]), 1);

        // Reset while ON
        latch_pulse(4'b0010, 4'd15);
        repeat (9) @(negedge clk);
        check("s6_oe_before", int'(g_oe[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s6_oe",   int'(g_oe[0]),   0);
        check("s6_busy", int'(g_busy[0]), 0);
        check("s6_exc",  int'(g_exc[0]),  1);
        check("s6_done", int'(g_done[0]), 0);
        check("s6_err",  int'(g_err[0]),  0);
        check_slot("s6_after", 0, 4'b0010, 4'd15, 0, 3, 46, 48);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
